// File: rtl/operand_fetch_stage.sv
// RV32I decode/operand-fetch stage: operand forwarding, immediate generation, load-use hazard
// detection and the ID/EX register. Define OPFETCH_STALL_CNT_EN to add the stall_count output.
module operand_fetch_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              id_ready,
    output logic [REG_AW-1:0] ReadAdd1,
    output logic [REG_AW-1:0] ReadAdd2,
    input  logic [XLEN-1:0]   Data1,
    input  logic [XLEN-1:0]   Data2,
    input  logic              write_en,
    input  logic [REG_AW-1:0] WriteAdd,
    input  logic [XLEN-1:0]   Reg_WriteData,
    input  logic              mem_fwd_valid,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rd,
    output logic [6:0]        ex_opcode,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
`ifdef OPFETCH_STALL_CNT_EN
    output logic [31:0]       stall_count,
`endif
    output logic              ex_is_load
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1, rs2;
    logic              uses_rs1, uses_rs2;
    logic [31:0]       imm32;
    logic [XLEN-1:0]   rs1_val, rs2_val;
    logic              hazard;

    logic              ex_valid_q;
    logic [XLEN-1:0]   ex_pc_q, ex_rs1_val_q, ex_rs2_val_q, ex_imm_q;
    logic [REG_AW-1:0] ex_rd_q;
    logic [6:0]        ex_opcode_q, ex_funct7_q;
    logic [2:0]        ex_funct3_q;
    logic              ex_is_load_q;

    assign opcode   = if_instr[6:0];
    assign rs1      = if_instr[15 +: REG_AW];
    assign rs2      = if_instr[20 +: REG_AW];
    assign ReadAdd1 = rs1;
    assign ReadAdd2 = rs2;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        imm32    = '0;
        case (opcode)
            OpR: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OpStore: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm32    = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OpBranch: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm32    = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                            if_instr[11:8], 1'b0};
            end
            OpImm, OpLoad, OpJalr: begin
                uses_rs1 = 1'b1;
                imm32    = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OpLui, OpAuipc: imm32 = {if_instr[31:12], 12'b0};
            OpJal: imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                            if_instr[30:21], 1'b0};
            default: ;
        endcase
    end

    // MEM result is younger than the WB write, so it wins; x0 is hardwired.
    always_comb begin
        rs1_val = Data1;
        if (rs1 == '0)                                 rs1_val = '0;
        else if (mem_fwd_valid && (mem_fwd_rd == rs1)) rs1_val = mem_fwd_data;
        else if (write_en && (WriteAdd == rs1))        rs1_val = Reg_WriteData;
    end

    always_comb begin
        rs2_val = Data2;
        if (rs2 == '0)                                 rs2_val = '0;
        else if (mem_fwd_valid && (mem_fwd_rd == rs2)) rs2_val = mem_fwd_data;
        else if (write_en && (WriteAdd == rs2))        rs2_val = Reg_WriteData;
    end

    assign hazard = if_valid && ex_valid_q && ex_is_load_q && (ex_rd_q != '0) &&
                    ((uses_rs1 && (ex_rd_q == rs1)) || (uses_rs2 && (ex_rd_q == rs2)));

    assign id_ready = flush || (!hazard && (!ex_valid_q || ex_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_rs1_val_q <= '0;
            ex_rs2_val_q <= '0;
            ex_imm_q     <= '0;
            ex_rd_q      <= '0;
            ex_opcode_q  <= '0;
            ex_funct3_q  <= '0;
            ex_funct7_q  <= '0;
            ex_is_load_q <= 1'b0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (ex_valid_q && !ex_ready) begin
            ex_valid_q <= ex_valid_q;
        end else if (hazard) begin
            ex_valid_q <= 1'b0;
        end else begin
            ex_valid_q <= if_valid;
            if (if_valid) begin
                ex_pc_q      <= if_pc;
                ex_rs1_val_q <= rs1_val;
                ex_rs2_val_q <= rs2_val;
                ex_imm_q     <= XLEN'($signed(imm32));
                ex_rd_q      <= if_instr[7 +: REG_AW];
                ex_opcode_q  <= opcode;
                ex_funct3_q  <= if_instr[14:12];
                ex_funct7_q  <= if_instr[31:25];
                ex_is_load_q <= (opcode == OpLoad);
            end
        end
    end

`ifdef OPFETCH_STALL_CNT_EN
    logic [31:0] stall_count_q;

    // Counts only genuine bubbles: flush and downstream backpressure take precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else if (!flush && !(ex_valid_q && !ex_ready) && hazard) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign stall_count = stall_count_q;
`endif

    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_pc_q;
    assign ex_rs1_val = ex_rs1_val_q;
    assign ex_rs2_val = ex_rs2_val_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rd      = ex_rd_q;
    assign ex_opcode  = ex_opcode_q;
    assign ex_funct3  = ex_funct3_q;
    assign ex_funct7  = ex_funct7_q;
    assign ex_is_load = ex_is_load_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: vector table, directed corner sequences and random stimulus
// against a behavioural model of the stage.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic [31:0] if_pc = '0;
    logic        id_ready;
    logic [4:0]  ReadAdd1, ReadAdd2;
    logic [31:0] Data1 = '0, Data2 = '0;
    logic        write_en = 1'b0;
    logic [4:0]  WriteAdd = '0;
    logic [31:0] Reg_WriteData = '0;
    logic        mem_fwd_valid = 1'b0;
    logic [4:0]  mem_fwd_rd = '0;
    logic [31:0] mem_fwd_data = '0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b1;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode, ex_funct7;
    logic [2:0]  ex_funct3;
    logic        ex_is_load;
`ifdef OPFETCH_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .id_ready      (id_ready),
        .ReadAdd1      (ReadAdd1),
        .ReadAdd2      (ReadAdd2),
        .Data1         (Data1),
        .Data2         (Data2),
        .write_en      (write_en),
        .WriteAdd      (WriteAdd),
        .Reg_WriteData (Reg_WriteData),
        .mem_fwd_valid (mem_fwd_valid),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_data  (mem_fwd_data),
        .flush         (flush),
        .ex_ready      (ex_ready),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_rs1_val    (ex_rs1_val),
        .ex_rs2_val    (ex_rs2_val),
        .ex_imm        (ex_imm),
        .ex_rd         (ex_rd),
        .ex_opcode     (ex_opcode),
        .ex_funct3     (ex_funct3),
        .ex_funct7     (ex_funct7),
`ifdef OPFETCH_STALL_CNT_EN
        .stall_count   (stall_count),
`endif
        .ex_is_load    (ex_is_load)
    );

    int tot = 0;
    int bad = 0;

    // Reference state of the ID/EX register.
    logic        m_valid;
    logic [31:0] m_pc, m_rs1, m_rs2, m_imm, m_rd, m_opc, m_f3, m_f7, m_ld, m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit uses1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011, 7'b1100111};
    endfunction

    function automatic bit uses2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    // Immediate value computed arithmetically from the instruction fields.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int v;
        v = 0;
        case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                v = int'(ins[31:20]);
                if (ins[31]) v -= 4096;
            end
            7'b0100011: begin
                v = int'({ins[31:25], ins[11:7]});
                if (ins[31]) v -= 4096;
            end
            7'b1100011: begin
                v = int'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
                if (ins[31]) v -= 8192;
            end
            7'b0110111, 7'b0010111: v = int'(ins & 32'hFFFF_F000);
            7'b1101111: begin
                v = int'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
                if (ins[31]) v -= 2097152;
            end
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_op(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return 32'd0;
        if (mem_fwd_valid && mem_fwd_rd == rs) return mem_fwd_data;
        if (write_en && WriteAdd == rs) return Reg_WriteData;
        return rf;
    endfunction

    function automatic bit ref_hazard();
        logic [6:0] op;
        op = if_instr[6:0];
        return if_valid && m_valid && (m_ld != 0) && (m_rd != 0) &&
               ((uses1(op) && m_rd == 32'(if_instr[19:15])) ||
                (uses2(op) && m_rd == 32'(if_instr[24:20])));
    endfunction

    function automatic bit ref_ready();
        return flush || (!ref_hazard() && (!m_valid || ex_ready));
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0;
        m_opc = 0; m_f3 = 0; m_f7 = 0; m_ld = 0; m_stall = 0;
    endtask

    // Applies one clock edge to the model using the inputs present at that edge.
    task automatic model_step(input bit haz);
        if (flush) begin
            m_valid = 1'b0;
        end else if (m_valid && !ex_ready) begin
            m_valid = m_valid;
        end else if (haz) begin
            m_valid = 1'b0;
            m_stall = m_stall + 1;
        end else begin
            m_valid = if_valid;
            if (if_valid) begin
                m_pc  = if_pc;
                m_rs1 = ref_op(if_instr[19:15], Data1);
                m_rs2 = ref_op(if_instr[24:20], Data2);
                m_imm = ref_imm(if_instr);
                m_rd  = 32'(if_instr[11:7]);
                m_opc = 32'(if_instr[6:0]);
                m_f3  = 32'(if_instr[14:12]);
                m_f7  = 32'(if_instr[31:25]);
                m_ld  = (if_instr[6:0] == 7'b0000011) ? 32'd1 : 32'd0;
            end
        end
    endtask

    task automatic compare_all();
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_pc", ex_pc, m_pc);
        chk("ex_rs1_val", ex_rs1_val, m_rs1);
        chk("ex_rs2_val", ex_rs2_val, m_rs2);
        chk("ex_imm", ex_imm, m_imm);
        chk("ex_rd", 32'(ex_rd), m_rd);
        chk("ex_opcode", 32'(ex_opcode), m_opc);
        chk("ex_funct3", 32'(ex_funct3), m_f3);
        chk("ex_funct7", 32'(ex_funct7), m_f7);
        chk("ex_is_load", 32'(ex_is_load), m_ld);
`ifdef OPFETCH_STALL_CNT_EN
        chk("stall_count", stall_count, m_stall);
`endif
    endtask

    // Inputs are already driven; check combinational outputs, clock once, check ID/EX.
    task automatic cycle();
        bit haz;
        #1;
        chk("id_ready", 32'(id_ready), 32'(ref_ready()));
        chk("ReadAdd1", 32'(ReadAdd1), 32'(if_instr[19:15]));
        chk("ReadAdd2", 32'(ReadAdd2), 32'(if_instr[24:20]));
        haz = ref_hazard();
        @(posedge clk);
        model_step(haz);
        #1;
        compare_all();
    endtask

    task automatic quiet_inputs();
        if_valid = 0; if_instr = 0; if_pc = 0; Data1 = 0; Data2 = 0;
        write_en = 0; WriteAdd = 0; Reg_WriteData = 0;
        mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        flush = 0; ex_ready = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        quiet_inputs();
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] d1, d2;
        logic        mfv;
        logic [4:0]  mfrd;
        logic [31:0] mfd;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] e_rs1, e_rs2, e_imm;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{32'h002081B3, 32'h5, 32'h7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h5, 32'h7, 32'h0, 5'd3};
        vecs[1]  = '{32'h002081B3, 32'h5, 32'h7, 1'b1, 5'd1, 32'hAAAA, 1'b1, 5'd1, 32'hBBBB,
                     32'hAAAA, 32'h7, 32'h0, 5'd3};
        vecs[2]  = '{32'h002081B3, 32'h5, 32'h7, 1'b0, 5'd1, 32'hAAAA, 1'b1, 5'd1, 32'hBBBB,
                     32'hBBBB, 32'h7, 32'h0, 5'd3};
        vecs[3]  = '{32'h002081B3, 32'h5, 32'h7, 1'b1, 5'd3, 32'hDDDD, 1'b1, 5'd2, 32'hCCCC,
                     32'h5, 32'hCCCC, 32'h0, 5'd3};
        vecs[4]  = '{32'h002001B3, 32'hFFFFFFFF, 32'h7, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0,
                     32'h5555, 32'h0, 32'h7, 32'h0, 5'd3};
        vecs[5]  = '{32'hFE000EE3, 32'h9, 32'h9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h0, 32'h0, 32'hFFFFFFFC, 5'd29};
        vecs[6]  = '{32'h12345037, 32'h11, 32'h22, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h11, 32'h22, 32'h12345000, 5'd0};
        vecs[7]  = '{32'hFE112E23, 32'h100, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h100, 32'h200, 32'hFFFFFFFC, 5'd28};
        vecs[8]  = '{32'hFFDFF0EF, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h3, 32'h4, 32'hFFFFFFFC, 5'd1};
        vecs[9]  = '{32'hFFF08293, 32'h77, 32'h88, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h77, 32'h88, 32'hFFFFFFFF, 5'd5};
        vecs[10] = '{32'h80000397, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h0, 32'h0, 32'h80000000, 5'd7};

        model_reset();
        #2;
        compare_all();
        do_reset();

        // Vector table: one accepted instruction per entry, no backpressure.
        for (int i = 0; i < 11; i++) begin
            if_valid = 1; if_instr = vecs[i].instr; if_pc = 32'h100 + 32'(i * 4);
            Data1 = vecs[i].d1; Data2 = vecs[i].d2;
            mem_fwd_valid = vecs[i].mfv; mem_fwd_rd = vecs[i].mfrd; mem_fwd_data = vecs[i].mfd;
            write_en = vecs[i].we; WriteAdd = vecs[i].wa; Reg_WriteData = vecs[i].wd;
            cycle();
            chk("vec_valid", 32'(ex_valid), 32'd1);
            chk("vec_rs1", ex_rs1_val, vecs[i].e_rs1);
            chk("vec_rs2", ex_rs2_val, vecs[i].e_rs2);
            chk("vec_imm", ex_imm, vecs[i].e_imm);
            chk("vec_rd", 32'(ex_rd), 32'(vecs[i].e_rd));
        end

        // Load-use: LW x5,0(x1) then ADD x6,x5,x5 gets exactly one bubble.
        do_reset();
        if_valid = 1; if_instr = 32'h0000A283; if_pc = 32'h200; Data1 = 32'h40;
        cycle();
        chk("lu_load_valid", 32'(ex_valid), 32'd1);
        if_instr = 32'h00528333; if_pc = 32'h204;
        #1;
        chk("lu_id_ready_low", 32'(id_ready), 32'd0);
        cycle();
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        cycle();
        chk("lu_issue_valid", 32'(ex_valid), 32'd1);
        chk("lu_issue_rd", 32'(ex_rd), 32'd6);
        chk("lu_issue_pc", ex_pc, 32'h204);
`ifdef OPFETCH_STALL_CNT_EN
        chk("lu_stall_count", stall_count, 32'd1);
`endif

        // Backpressure for 3 cycles, then flush while still stalled.
        quiet_inputs();
        if_valid = 1; if_instr = 32'h002081B3; if_pc = 32'h500; Data1 = 32'h11; Data2 = 32'h22;
        cycle();
        if_instr = 32'hFFF08293; if_pc = 32'h504; Data1 = 32'h99; ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_id_ready", 32'(id_ready), 32'd0);
            cycle();
            chk("bp_valid_hold", 32'(ex_valid), 32'd1);
            chk("bp_pc_hold", ex_pc, 32'h500);
            chk("bp_rs1_hold", ex_rs1_val, 32'h11);
        end
        flush = 1;
        #1;
        chk("fl_id_ready", 32'(id_ready), 32'd1);
        cycle();
        chk("fl_valid", 32'(ex_valid), 32'd0);
        flush = 0; ex_ready = 1;

        // Asynchronous reset between edges while ex_valid is high.
        if_instr = 32'h002081B3; if_pc = 32'h300; Data1 = 32'h5; Data2 = 32'h6;
        cycle();
        chk("ar_pre_valid", 32'(ex_valid), 32'd1);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("ar_valid_now", 32'(ex_valid), 32'd0);
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1;
        cycle();
        chk("ar_resume_valid", 32'(ex_valid), 32'd1);
        chk("ar_resume_pc", ex_pc, 32'h300);

        // Random traffic over a small register window to provoke hazards and forwarding.
        for (int n = 0; n < 400; n++) begin
            logic [6:0] ops[10];
            logic [31:0] ins;
            ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011,
                    7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111};
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 9)];
            ins[11:7] = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            if_instr = ins;
            if_pc = $urandom;
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 9) == 0);
            Data1 = $urandom; Data2 = $urandom;
            write_en = $urandom_range(0, 1) == 1; WriteAdd = 5'($urandom_range(0, 3));
            Reg_WriteData = $urandom;
            mem_fwd_valid = $urandom_range(0, 1) == 1; mem_fwd_rd = 5'($urandom_range(0, 3));
            mem_fwd_data = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage of the multicycle pipelined RV32I core.
- Drives the register_set read addresses and consumes Data1/Data2.
- Applies forwarding from the MEM stage and the WB write port, generates immediates, detects load-use hazards, and holds the ID/EX pipeline register with valid/ready backpressure and flush.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
if_valid  input  1  IF/ID holds a valid instruction
if_instr  input  32  instruction word
if_pc  input  XLEN  instruction PC
id_ready  output  1  ID accepts the instruction this cycle
ReadAdd1  output  REG_AW  register_set read address 1 (instr[19:15])
ReadAdd2  output  REG_AW  register_set read address 2 (instr[24:20])
Data1  input  XLEN  register_set read data 1
Data2  input  XLEN  register_set read data 2
write_en  input  1  WB write enable (same net as register_set)
WriteAdd  input  REG_AW  WB write address
Reg_WriteData  input  XLEN  WB write data
mem_fwd_valid  input  1  MEM holds a final result for mem_fwd_rd
mem_fwd_rd  input  REG_AW  MEM destination register
mem_fwd_data  input  XLEN  MEM result
flush  input  1  taken branch/jump; kill ID and EX
ex_ready  input  1  EX accepts the ID/EX contents
ex_valid  output  1  ID/EX holds a valid instruction
ex_pc  output  XLEN  registered PC
ex_rs1_val  output  XLEN  registered operand 1
ex_rs2_val  output  XLEN  registered operand 2
ex_imm  output  XLEN  registered sign-extended immediate
ex_rd  output  REG_AW  registered destination register
ex_opcode  output  7  registered opcode
ex_funct3  output  3  registered funct3
ex_funct7  output  7  registered funct7
ex_is_load  output  1  registered: opcode == 0000011

Behaviour:
- Reset (rst_n low, asynchronous): all ex_* outputs are 0, including ex_valid. Read addresses and id_ready are combinational.
- Operand usage by opcode:
  - rs1 and rs2: R 0110011, STORE 0100011, BRANCH 1100011.
  - rs1 only: OP-IMM 0010011, LOAD 0000011, JALR 1100111.
  - Neither: LUI, AUIPC, JAL.
- Immediates are sign-extended from instr[31]:
  - I-type: OP-IMM, LOAD, JALR.
  - S-type: STORE.
  - B-type: BRANCH, bit0 = 0.
  - U-type: LUI, AUIPC, low 12 bits = 0.
  - J-type: JAL, bit0 = 0.
  - Any other opcode: 0.
- Operand select per rs, in priority order:
  1. rs == 0 -> 0.
  2. mem_fwd_valid && mem_fwd_rd == rs -> mem_fwd_data.
  3. write_en && WriteAdd == rs -> Reg_WriteData. This covers a same-cycle write, because register_set reads the pre-write value.
  4. Otherwise Data1 or Data2.
- Load-use hazard (combinational): if_valid && ex_valid && ex_is_load && ex_rd != 0 && ex_rd equals a used rs.
- id_ready = flush || (!hazard && (!ex_valid || ex_ready)).
- ID/EX update on each rising clk edge; the first matching rule applies:
  1. flush: ex_valid <= 0. The ID instruction is consumed and dropped.
  2. ex_valid && !ex_ready: hold every ex_* output.
  3. hazard: ex_valid <= 0 (bubble). The ID instruction is held upstream because id_ready = 0.
  4. Otherwise: ex_valid <= if_valid. The payload loads only when if_valid; otherwise the payload holds.
- Latency: one cycle from acceptance to ex_valid. A load-use hazard adds exactly one bubble cycle.
- Operands captured into ID/EX are never refreshed while held.
- ex_rd is loaded from instr[11:7] for all opcodes. Downstream gates writes by opcode.
- A flush during reset has no effect; reset dominates.

Optional Feature:
- Macro OPFETCH_STALL_CNT_EN.
- When defined:
  - Adds output stall_count [31:0], reset to 0.
  - Increments on every edge where rule 3 (hazard bubble) applies.
  - Wraps from 0xFFFFFFFF to 0.
- When undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
1. Forwarding priority, plain read: ADD x3,x1,x2 (0x002081B3) with Data1=5, Data2=7, no forwarding -> next cycle ex_valid=1, ex_rs1_val=5, ex_rs2_val=7, ex_rd=3.
2. Forwarding priority, MEM over WB: rs1=x1 with mem_fwd(x1,0xAAAA) and write_en(x1,0xBBBB) both active -> ex_rs1_val=0xAAAA. With only WB active -> 0xBBBB. For an instruction reading x0 with Data1=0xFFFFFFFF, mem_fwd_valid=1, mem_fwd_rd=0 -> ex_rs1_val=0.
3. Load-use: LW x5,0(x1), then ADD x6,x5,x5 -> one cycle with id_ready=0 and ex_valid=0, then ADD issues. With OPFETCH_STALL_CNT_EN defined, stall_count=1.
4. Immediates: BEQ 0xFE000EE3 -> ex_imm=0xFFFFFFFC. LUI 0x12345037 -> ex_imm=0x12345000. SW 0xFE112E23 -> ex_imm=0xFFFFFFFC.
5. Backpressure and flush: hold ex_ready=0 for 3 cycles -> ex_* outputs stable and id_ready=0. Then assert flush with ex_ready=0 -> next edge ex_valid=0 and id_ready=1 during the flush cycle.
6. Asynchronous reset mid-operation: drop rst_n between edges while ex_valid=1 -> ex_valid and all ex_* outputs go to 0 immediately (and stall_count=0 if enabled). Normal issue resumes the first edge after rst_n rises.
